rfile_wb_arb: RTL and testbench

RFILE_WB_ARB -- requirements
Module: rfile_wb_arb

---
 rtl/rfile_wb_arb.sv | 103 ++++++++++
 tb/tb_rfile_wb_arb.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rfile_wb_arb.sv
// rfile_wb_arb: round-robin writeback arbiter onto NPORTS register-file
// write ports, with same-address suppression and a saturating stall counter.
module rfile_wb_arb #(
    parameter int NREQ       = 4,
    parameter int NPORTS     = 2,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic [NREQ-1:0]                      req_valid,
    input  logic [NREQ-1:0][ADDR_WIDTH-1:0]      req_addr,
    input  logic [NREQ-1:0][DATA_WIDTH-1:0]      req_data,
    output logic [NREQ-1:0]                      req_ready,
    output logic [NPORTS-1:0][ADDR_WIDTH-1:0]    wr_addr,
    output logic [NPORTS-1:0]                    wr_enable,
    output logic [NPORTS-1:0][DATA_WIDTH-1:0]    wr_data,
    output logic [15:0]                          stall_cnt
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]                       r_rr_ptr;
    logic [NPORTS-1:0]                   r_wr_en;
    logic [NPORTS-1:0][ADDR_WIDTH-1:0]   r_wr_addr;
    logic [NPORTS-1:0][DATA_WIDTH-1:0]   r_wr_data;
    logic [15:0]                         r_stall;

    logic [NREQ-1:0]                     w_ready;
    logic [NPORTS-1:0]                   w_port_en;
    logic [NPORTS-1:0][ADDR_WIDTH-1:0]   w_port_addr;
    logic [NPORTS-1:0][DATA_WIDTH-1:0]   w_port_data;
    logic [PW-1:0]                       w_next_ptr;
    logic                                w_stall;

    // A request is shadowed by any earlier-priority valid request to the
    // same nonzero register, whether or not that earlier one wins a port.
    always_comb begin
        int  idx;
        int  jdx;
        int  used;
        logic dup;
        w_ready     = '0;
        w_port_en   = '0;
        w_port_addr = '0;
        w_port_data = '0;
        w_next_ptr  = r_rr_ptr;
        idx         = 0;
        jdx         = 0;
        used        = 0;
        dup         = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(r_rr_ptr) + k) % NREQ;
            dup = 1'b0;
            for (int j = 0; j < NREQ; j++) begin
                jdx = (int'(r_rr_ptr) + j) % NREQ;
                if (j < k && req_valid[jdx] && req_addr[jdx] != '0
                    && req_addr[jdx] == req_addr[idx])
                    dup = 1'b1;
            end
            if (req_valid[idx]) begin
                if (req_addr[idx] == '0) begin
                    w_ready[idx] = 1'b1;
                end else if (!dup && used < NPORTS) begin
                    w_ready[idx]      = 1'b1;
                    w_port_en[used]   = 1'b1;
                    w_port_addr[used] = req_addr[idx];
                    w_port_data[used] = req_data[idx];
                    w_next_ptr        = PW'((idx + 1) % NREQ);
                    used              = used + 1;
                end
            end
        end
    end

    assign w_stall   = |(req_valid & ~w_ready);
    assign req_ready = reset_n ? w_ready : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr  <= '0;
            r_wr_en   <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_stall   <= '0;
        end else begin
            r_rr_ptr <= w_next_ptr;
            r_wr_en  <= w_port_en;
            for (int p = 0; p < NPORTS; p++) begin
                if (w_port_en[p]) begin
                    r_wr_addr[p] <= w_port_addr[p];
                    r_wr_data[p] <= w_port_data[p];
                end
            end
            if (w_stall && r_stall != 16'hFFFF)
                r_stall <= r_stall + 16'd1;
        end
    end

    assign wr_enable = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign stall_cnt = r_stall;
endmodule

// File: tb/tb_rfile_wb_arb.sv
// tb_rfile_wb_arb: directed vectors with a per-cycle reference model of
// the writeback arbiter plus hand-computed literal checks.
module tb_rfile_wb_arb;
    localparam int NREQ   = 4;
    localparam int NPORTS = 2;
    localparam int AW     = 5;
    localparam int DW     = 32;

    logic                         clock = 1'b0;
    logic                         reset_n;
    logic [NREQ-1:0]              req_valid;
    logic [NREQ-1:0][AW-1:0]      req_addr;
    logic [NREQ-1:0][DW-1:0]      req_data;
    logic [NREQ-1:0]              req_ready;
    logic [NPORTS-1:0][AW-1:0]    wr_addr;
    logic [NPORTS-1:0]            wr_enable;
    logic [NPORTS-1:0][DW-1:0]    wr_data;
    logic [15:0]                  stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    rfile_wb_arb #(
        .NREQ(NREQ), .NPORTS(NPORTS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .wr_addr(wr_addr), .wr_enable(wr_enable),
        .wr_data(wr_data), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference model: priority list, set of claimed addresses, port queue.
    int              m_ptr   = 0;
    logic [NPORTS-1:0] m_en  = '0;
    logic [AW-1:0]   m_addr[NPORTS] = '{default: '0};
    logic [DW-1:0]   m_data[NPORTS] = '{default: '0};
    int              m_stall = 0;
    int              gq[$];
    bit              seen[int];
    logic [NREQ-1:0] erdy;

    always @(negedge clock) begin
        erdy = '0;
        gq.delete();
        seen.delete();
        if (!reset_n) begin
            m_ptr   = 0;
            m_en    = '0;
            m_stall = 0;
            for (int p = 0; p < NPORTS; p++) begin
                m_addr[p] = '0;
                m_data[p] = '0;
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (req_valid[i]) begin
                    if (req_addr[i] == 0) begin
                        erdy[i] = 1'b1;
                    end else if (!seen.exists(int'(req_addr[i]))) begin
                        seen[int'(req_addr[i])] = 1'b1;
                        if (gq.size() < NPORTS) begin
                            gq.push_back(i);
                            erdy[i] = 1'b1;
                        end
                    end
                end
            end
        end
        chk("req_ready", 64'(req_ready), 64'(erdy));
        chk("wr_enable", 64'(wr_enable), 64'(m_en));
        for (int p = 0; p < NPORTS; p++) begin
            chk($sformatf("wr_addr%0d", p), 64'(wr_addr[p]), 64'(m_addr[p]));
            chk($sformatf("wr_data%0d", p), 64'(wr_data[p]), 64'(m_data[p]));
        end
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        if (reset_n) begin
            m_en = '0;
            for (int p = 0; p < gq.size(); p++) begin
                m_en[p]   = 1'b1;
                m_addr[p] = req_addr[gq[p]];
                m_data[p] = req_data[gq[p]];
            end
            if (gq.size() > 0)
                m_ptr = (gq[gq.size()-1] + 1) % NREQ;
            if ((req_valid & ~erdy) != '0 && m_stall < 65535)
                m_stall++;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    int grants[NREQ];
    int waits[NREQ];
    int maxw;

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        step();
        step();
        reset_n = 1'b1;

        // four distinct writebacks, two ports
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i] = AW'(i + 1);
            req_data[i] = DW'(32'hA0 + i);
        end
        #2 chk("t1_ready0", 64'(req_ready), 64'b0011);
        step();
        chk("t1_en", 64'(wr_enable), 64'b11);
        chk("t1_a0", 64'(wr_addr[0]), 64'd1);
        chk("t1_a1", 64'(wr_addr[1]), 64'd2);
        chk("t1_d0", 64'(wr_data[0]), 64'hA0);
        #2 chk("t1_ready1", 64'(req_ready), 64'b1100);
        step();
        chk("t1_a0b", 64'(wr_addr[0]), 64'd3);
        chk("t1_a1b", 64'(wr_addr[1]), 64'd4);
        req_valid = '0;
        step();

        // same destination register from two requesters
        req_valid   = 4'b0110;
        req_addr[1] = 5'd7;
        req_addr[2] = 5'd7;
        req_data[1] = 32'h11;
        req_data[2] = 32'h22;
        #2 chk("t2_ready0", 64'(req_ready), 64'b0010);
        step();
        chk("t2_en", 64'(wr_enable), 64'b01);
        chk("t2_a0", 64'(wr_addr[0]), 64'd7);
        chk("t2_d0", 64'(wr_data[0]), 64'h11);
        req_valid = 4'b0100;
        #2 chk("t2_ready1", 64'(req_ready), 64'b0100);
        step();
        chk("t2_d0b", 64'(wr_data[0]), 64'h22);
        req_valid   = 4'b1000;
        req_addr[3] = 5'd9;
        step();
        req_valid = '0;
        step();

        // x0 writes bypass the ports
        req_valid   = 4'b1111;
        req_addr[0] = 5'd0;
        req_addr[1] = 5'd5;
        req_addr[2] = 5'd6;
        req_addr[3] = 5'd8;
        #2 chk("t3_ready", 64'(req_ready), 64'b0111);
        chk("t3_stall0", 64'(stall_cnt), 64'd3);
        step();
        chk("t3_en", 64'(wr_enable), 64'b11);
        chk("t3_a0", 64'(wr_addr[0]), 64'd5);
        chk("t3_a1", 64'(wr_addr[1]), 64'd6);
        chk("t3_stall1", 64'(stall_cnt), 64'd4);
        req_valid = '0;
        step();

        // fairness under full load
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i] = AW'(i + 1);
            grants[i]   = 0;
            waits[i]    = 0;
        end
        maxw = 0;
        for (int c = 0; c < 8; c++) begin
            #2;
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    grants[i]++;
                    waits[i] = 0;
                end else begin
                    waits[i]++;
                    if (waits[i] > maxw) maxw = waits[i];
                end
            end
            step();
        end
        for (int i = 0; i < NREQ; i++)
            chk($sformatf("t4_grants%0d", i), 64'(grants[i]), 64'd4);
        chk("t4_maxwait", 64'(maxw <= 2), 64'd1);
        chk("t4_stall", 64'(stall_cnt), 64'd12);

        // sustained conflict drives the stall counter into saturation
        req_valid   = 4'b0011;
        req_addr[0] = 5'd5;
        req_addr[1] = 5'd5;
        repeat (65530) step();
        chk("t5_sat0", 64'(stall_cnt), 64'hFFFF);
        repeat (5) step();
        chk("t5_sat1", 64'(stall_cnt), 64'hFFFF);

        // asynchronous reset while req0 is being accepted
        req_valid   = 4'b0001;
        req_addr[0] = 5'd3;
        req_data[0] = 32'h33;
        #1 chk("t6_ready", 64'(req_ready), 64'b0001);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_en", 64'(wr_enable), 64'd0);
        chk("t6_stall", 64'(stall_cnt), 64'd0);
        chk("t6_rdy", 64'(req_ready), 64'd0);
        chk("t6_a0", 64'(wr_addr[0]), 64'd0);
        step();
        reset_n   = 1'b1;
        req_valid = '0;
        step();
        chk("t6_nowr0", 64'(wr_enable), 64'd0);
        step();
        chk("t6_nowr1", 64'(wr_enable), 64'd0);
        req_valid = 4'b0001;
        step();
        chk("t6_rewr_en", 64'(wr_enable), 64'b01);
        chk("t6_rewr_a", 64'(wr_addr[0]), 64'd3);
        req_valid = '0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
